// File: rtl/mips_bus_arbiter.sv
// Two-master, one-slave arbiter for the CPU's Avalon-style RAM port.
// m0 = instruction fetch (read-only), m1 = load/store. Grant is held until the transfer completes.
module mips_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata
);

  typedef enum logic [1:0] {IDLE, OWN_M0, OWN_M1} owner_t;

  owner_t owner, owner_nxt;
  logic   last, last_nxt;   // master that completed most recently: 0 = m0, 1 = m1
  logic   req0, req1;
  logic   gnt0, gnt1;

  assign req0 = m0_read;
  assign req1 = m1_read | m1_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner <= IDLE;
      last  <= 1'b1;
    end else begin
      owner <= owner_nxt;
      last  <= last_nxt;
    end
  end

  // Grant and next state. In IDLE the winner is picked in the same cycle so an
  // uncontended request reaches the RAM with no added latency.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    owner_nxt = owner;
    last_nxt  = last;
    case (owner)
      OWN_M0: gnt0 = 1'b1;
      OWN_M1: gnt1 = 1'b1;
      default: begin
        if (req0 && req1) begin
          if ((FIXED_PRIORITY != 0) || !last) gnt1 = 1'b1;
          else                                gnt0 = 1'b1;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end
    endcase

    // A dropped strobe while owning is an abort: release without updating last.
    if (gnt0) begin
      if (!req0) begin
        owner_nxt = IDLE;
      end else if (!s_waitrequest) begin
        owner_nxt = IDLE;
        last_nxt  = 1'b0;
      end else begin
        owner_nxt = OWN_M0;
      end
    end else if (gnt1) begin
      if (!req1) begin
        owner_nxt = IDLE;
      end else if (!s_waitrequest) begin
        owner_nxt = IDLE;
        last_nxt  = 1'b1;
      end else begin
        owner_nxt = OWN_M1;
      end
    end
  end

  // Slave-side mux; reset forces the bus quiet combinationally.
  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    if (!reset) begin
      if (gnt0) begin
        s_address      = m0_address;
        s_read         = m0_read;
        s_byteenable   = '1;
        m0_waitrequest = s_waitrequest;
      end else if (gnt1) begin
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
      end
    end
  end

  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter: round-robin and fixed-priority instances checked
// every cycle against a grant/lock model, plus directed scenarios with literal expectations.
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m0_address = '0, m1_address = '0, m1_writedata = '0;
  logic        m0_read = 1'b0, m1_read = 1'b0, m1_write = 1'b0, s_waitrequest = 1'b0;
  logic [3:0]  m1_byteenable = '0;
  logic [31:0] s_readdata = '0, f_s_readdata = '0;

  logic        m0_waitrequest, m1_waitrequest, s_read, s_write;
  logic [31:0] m0_readdata, m1_readdata, s_address, s_writedata;
  logic [3:0]  s_byteenable;
  logic        f_m0_waitrequest, f_m1_waitrequest, f_s_read, f_s_write;
  logic [31:0] f_m0_readdata, f_m1_readdata, f_s_address, f_s_writedata;
  logic [3:0]  f_s_byteenable;

  mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIORITY(0)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_byteenable(m1_byteenable), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
    .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest), .s_readdata(s_readdata));

  mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_waitrequest(f_m0_waitrequest), .m0_readdata(f_m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_byteenable(m1_byteenable), .m1_waitrequest(f_m1_waitrequest), .m1_readdata(f_m1_readdata),
    .s_address(f_s_address), .s_read(f_s_read), .s_write(f_s_write), .s_writedata(f_s_writedata),
    .s_byteenable(f_s_byteenable), .s_waitrequest(s_waitrequest), .s_readdata(f_s_readdata));

  always #5 clk = ~clk;

  int          tests = 0, fails = 0;
  logic [31:0] mem [4096];
  int          lock [2];       // master holding the bus, -1 when free
  int          last [2];       // master that completed most recently
  bit          m0_act = 0, m1_act = 0, m1_wr = 0;
  logic [31:0] a0 = '0, a1 = '0, wd1 = '0;
  logic [3:0]  be1 = '0;
  int          done0;
  int          order [$];
  logic        ob_w0, ob_w1, ob_sr, ob_sw, ob_fw0, ob_fw1, ob_fsr;
  logic [31:0] ob_sa, ob_rd0, ob_rd1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: who owns the bus this cycle follows from lock/last and the request rules.
  task automatic check_inst(input int k, input logic [31:0] sa, input logic sr, input logic sw,
                            input logic [31:0] swd, input logic [3:0] sbe, input logic w0,
                            input logic w1, input logic [31:0] rd0, input logic [31:0] rd1,
                            input logic [31:0] srd, output int dn);
    int g;
    bit r0, r1, rg;
    logic [31:0] e_sa, e_swd;
    logic e_sr, e_sw, e_w0, e_w1;
    logic [3:0] e_sbe;
    string p;
    p  = (k == 0) ? "rr" : "fp";
    r0 = m0_read;
    r1 = m1_read | m1_write;
    g  = -1;
    dn = -1;
    if (!reset) begin
      if (lock[k] >= 0)  g = lock[k];
      else if (r0 && r1) g = (k == 1 || last[k] == 0) ? 1 : 0;
      else if (r0)       g = 0;
      else if (r1)       g = 1;
    end
    e_sa = '0; e_swd = '0; e_sr = 0; e_sw = 0; e_sbe = '0; e_w0 = 1; e_w1 = 1;
    if (g == 0) begin
      e_sa = m0_address; e_sr = m0_read; e_sbe = 4'hF; e_w0 = s_waitrequest;
    end else if (g == 1) begin
      e_sa = m1_address; e_sr = m1_read; e_sw = m1_write; e_swd = m1_writedata;
      e_sbe = m1_byteenable; e_w1 = s_waitrequest;
    end
    chk({p, "_s_address"}, sa, e_sa);
    chk({p, "_s_read"}, {31'd0, sr}, {31'd0, e_sr});
    chk({p, "_s_write"}, {31'd0, sw}, {31'd0, e_sw});
    chk({p, "_s_writedata"}, swd, e_swd);
    chk({p, "_s_byteenable"}, {28'd0, sbe}, {28'd0, e_sbe});
    chk({p, "_m0_waitrequest"}, {31'd0, w0}, {31'd0, e_w0});
    chk({p, "_m1_waitrequest"}, {31'd0, w1}, {31'd0, e_w1});
    chk({p, "_m0_readdata"}, rd0, srd);
    chk({p, "_m1_readdata"}, rd1, srd);
    if (reset) begin
      lock[k] = -1;
      last[k] = 1;
    end else if (g >= 0) begin
      rg = (g == 0) ? r0 : r1;
      if (!rg) lock[k] = -1;
      else if (!s_waitrequest) begin
        lock[k] = -1;
        last[k] = g;
        dn = g;
      end else lock[k] = g;
    end
  endtask

  task automatic cycle(input bit rst_v, input bit wt);
    int dn_f;
    #1;
    reset         = rst_v;
    m0_read       = m0_act;
    m0_address    = a0;
    m1_read       = m1_act && !m1_wr;
    m1_write      = m1_act && m1_wr;
    m1_address    = a1;
    m1_writedata  = wd1;
    m1_byteenable = be1;
    s_waitrequest = wt;
    #1;
    s_readdata   = mem[s_address[13:2]];
    f_s_readdata = mem[f_s_address[13:2]];
    @(negedge clk);
    check_inst(0, s_address, s_read, s_write, s_writedata, s_byteenable, m0_waitrequest,
               m1_waitrequest, m0_readdata, m1_readdata, s_readdata, done0);
    check_inst(1, f_s_address, f_s_read, f_s_write, f_s_writedata, f_s_byteenable, f_m0_waitrequest,
               f_m1_waitrequest, f_m0_readdata, f_m1_readdata, f_s_readdata, dn_f);
    chk("both_served_same_cycle", {31'd0, !m0_waitrequest && !m1_waitrequest}, 32'd0);
    chk("illegal_m1_read_write", {31'd0, m1_read && m1_write}, 32'd0);
    ob_w0 = m0_waitrequest; ob_w1 = m1_waitrequest; ob_sr = s_read; ob_sw = s_write;
    ob_sa = s_address; ob_rd0 = m0_readdata; ob_rd1 = m1_readdata;
    ob_fw0 = f_m0_waitrequest; ob_fw1 = f_m1_waitrequest; ob_fsr = f_s_read;
    if (done0 == 0) begin
      chk("m0_load_data", m0_readdata, mem[a0[13:2]]);
      m0_act = 0;
      order.push_back(0);
    end else if (done0 == 1) begin
      if (m1_wr) begin
        for (int b = 0; b < 4; b++)
          if (be1[b]) mem[a1[13:2]][8*b +: 8] = wd1[8*b +: 8];
      end else chk("m1_load_data", m1_readdata, mem[a1[13:2]]);
      m1_act = 0;
      order.push_back(1);
    end
    @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    for (int k = 0; k < 2; k++) begin lock[k] = -1; last[k] = 1; end

    cycle(1, 0);
    cycle(1, 1);
    chk("reset_m0_waitrequest", {31'd0, ob_w0}, 32'd1);
    chk("reset_m1_waitrequest", {31'd0, ob_w1}, 32'd1);
    chk("reset_s_read", {31'd0, ob_sr}, 32'd0);

    // Single fetch with two RAM stall cycles.
    mem[0] = 32'h1234_5678;
    m0_act = 1; a0 = 32'hBFC0_0000;
    for (int i = 0; i < 3; i++) begin
      cycle(0, i < 2);
      chk("fetch_m0_waitrequest", {31'd0, ob_w0}, (i < 2) ? 32'd1 : 32'd0);
      chk("fetch_s_address", ob_sa, 32'hBFC0_0000);
      chk("fetch_s_read", {31'd0, ob_sr}, 32'd1);
      chk("fetch_m1_waitrequest", {31'd0, ob_w1}, 32'd1);
    end
    chk("fetch_readdata", ob_rd0, 32'h1234_5678);
    chk("fetch_done", done0, 0);

    // Partial store then load by m1.
    m1_act = 1; m1_wr = 1; a1 = 32'h0000_1000; wd1 = 32'hDEAD_BEEF; be1 = 4'b0011;
    cycle(0, 0);
    chk("store_s_write", {31'd0, ob_sw}, 32'd1);
    chk("store_done", done0, 1);
    m1_act = 1; m1_wr = 0; be1 = 4'hF;
    cycle(0, 0);
    chk("load_s_write", {31'd0, ob_sw}, 32'd0);
    chk("load_readdata", ob_rd1, 32'h0000_BEEF);

    // Continuous contention, zero-wait RAM: strict alternation starting with m0.
    order.delete();
    for (int i = 0; i < 6; i++) begin
      if (!m0_act) begin m0_act = 1; a0 = 32'h0000_0100 + 32'(4 * i); end
      if (!m1_act) begin m1_act = 1; m1_wr = 0; a1 = 32'h0000_0200 + 32'(4 * i); end
      cycle(0, 0);
    end
    chk("rr_count", order.size(), 6);
    for (int i = 0; i < 6 && i < order.size(); i++) chk("rr_order", order[i], i % 2);
    m0_act = 0; m1_act = 0;

    // Grant lock: m1 write arrives while m0 is stalled.
    a0 = 32'h0000_0300;
    m0_act = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin m1_act = 1; m1_wr = 1; a1 = 32'h0000_0400; wd1 = 32'hCAFE_F00D; be1 = 4'hF; end
      cycle(0, i < 3);
      chk("lock_s_address", ob_sa, 32'h0000_0300);
      chk("lock_s_write", {31'd0, ob_sw}, 32'd0);
    end
    chk("lock_m0_done", done0, 0);
    cycle(0, 0);
    chk("lock_m1_next", done0, 1);
    chk("lock_m1_s_write", {31'd0, ob_sw}, 32'd1);

    // Owner drops its strobe mid-transfer: bus frees, m0 then served.
    m1_act = 1; m1_wr = 0; a1 = 32'h0000_0500;
    cycle(0, 1);
    m1_act = 0; m0_act = 1; a0 = 32'h0000_0600;
    cycle(0, 0);
    chk("abort_m0_blocked", {31'd0, ob_w0}, 32'd1);
    cycle(0, 0);
    chk("abort_m0_served", done0, 0);

    // Reset during the stall of an m1 write.
    m1_act = 1; m1_wr = 1; a1 = 32'h0000_0700; wd1 = 32'h1111_2222; be1 = 4'hF;
    cycle(0, 1);
    cycle(1, 1);
    chk("rst_mid_s_write", {31'd0, ob_sw}, 32'd0);
    chk("rst_mid_m0_wait", {31'd0, ob_w0}, 32'd1);
    chk("rst_mid_m1_wait", {31'd0, ob_w1}, 32'd1);
    m0_act = 1; a0 = 32'h0000_0800; m1_act = 1; m1_wr = 0; a1 = 32'h0000_0900;
    cycle(0, 0);
    chk("rst_after_m0_first", done0, 0);

    // Fixed priority: m1 takes every tie.
    m0_act = 0; m1_act = 0;
    cycle(1, 0);
    for (int i = 0; i < 4; i++) begin
      if (!m0_act) begin m0_act = 1; a0 = 32'h0000_0A00; end
      if (!m1_act) begin m1_act = 1; m1_wr = 0; a1 = 32'h0000_0B00; end
      cycle(0, 0);
      chk("fp_m1_waitrequest", {31'd0, ob_fw1}, 32'd0);
      chk("fp_m0_waitrequest", {31'd0, ob_fw0}, 32'd1);
      chk("fp_s_read", {31'd0, ob_fsr}, 32'd1);
    end

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if (!m0_act && $urandom_range(99) < 60) begin
        m0_act = 1; a0 = $urandom & 32'hFFFF_FFFC;
      end
      if (!m1_act && $urandom_range(99) < 60) begin
        m1_act = 1; m1_wr = $urandom_range(1); a1 = $urandom & 32'hFFFF_FFFC;
        wd1 = $urandom; be1 = 4'($urandom);
      end
      cycle(0, $urandom_range(99) < 40);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the Avalon-style memory bus of the MIPS CPU.
- It shares the single RAM port between the instruction-fetch master (m0, read-only) and the data master (m1, read/write).
- Grant is locked for the full duration of a transfer, including all waitrequest stall cycles; ties are resolved round-robin or by fixed priority.
- It sits between the CPU's fetch/load-store units and the RAM_32x4096 slave interface.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- FIXED_PRIORITY, 0: 0 = round-robin on ties; 1 = m1 always wins ties.

Ports:
- clk  in  1  clock, rising edge active
- reset  in  1  asynchronous, active-high reset
- m0_address  in  ADDR_W  fetch address
- m0_read  in  1  fetch request
- m0_waitrequest  out  1  fetch stall
- m0_readdata  out  DATA_W  fetch data
- m1_address  in  ADDR_W  data address
- m1_read  in  1  data read request
- m1_write  in  1  data write request
- m1_writedata  in  DATA_W  store data
- m1_byteenable  in  DATA_W/8  store/load lanes
- m1_waitrequest  out  1  data stall
- m1_readdata  out  DATA_W  load data
- s_address  out  ADDR_W  to RAM
- s_read  out  1  to RAM
- s_write  out  1  to RAM
- s_writedata  out  DATA_W  to RAM
- s_byteenable  out  DATA_W/8  to RAM
- s_waitrequest  in  1  from RAM
- s_readdata  in  DATA_W  from RAM

Behaviour:
- Bus protocol: a transfer completes in the cycle where the master strobe (read/write) is high and its waitrequest is low. readdata is valid in that cycle. A master holds address, strobe and data stable until completion.
- State register `owner`: IDLE, OWN_M0, OWN_M1. Register `last` holds the master that most recently completed; it resets to M1, so M0 wins the first tie.
- Reset, asynchronous: owner=IDLE, last=M1. While reset is high: s_read=s_write=0, m0_waitrequest=m1_waitrequest=1, s_address=0, s_writedata=0, s_byteenable=0.
- IDLE: winner is chosen combinationally in the same cycle, giving zero added latency.
  - Only m0 requests: m0 wins.
  - Only m1 (read|write) requests: m1 wins.
  - Both request:
    - FIXED_PRIORITY=1: m1 wins.
    - Otherwise: the master that is not `last` wins.
  - The winner is routed to the slave in that cycle.
  - s_waitrequest=0: transfer completes, owner stays IDLE, last=winner.
  - s_waitrequest=1: owner<=winner.
- OWN_Mx: route Mx only; no re-arbitration. When s_waitrequest=0: complete, owner<=IDLE, last<=Mx.
- Routing when m0 is granted: s_address=m0_address, s_read=m0_read, s_write=0, s_byteenable=4'b1111, s_writedata=0.
- Routing when m1 is granted: all m1 signals pass through.
- Waitrequest outputs:
  - Granted master sees s_waitrequest.
  - Non-granted requesting master sees 1.
  - Idle master with no request sees 1.
- readdata: both m0_readdata and m1_readdata are driven from s_readdata unconditionally. Masters qualify it with their own waitrequest.
- No requests: s_read=s_write=0, outputs otherwise 0.
- m1_read and m1_write both high is illegal. The arbiter forwards both and asserts nothing extra; the bench must flag it.
- Owner drops its strobe mid-transfer (protocol violation): treat as an abort, owner<=IDLE next cycle, last unchanged.
- Reset mid-transfer: strobes drop immediately and state is lost. The slave must tolerate this.
- Back-to-back transfers: a master re-requesting in the cycle after completion competes normally. With round-robin, two continuously requesting masters alternate, so there is no starvation.

Test Plan:
- Single fetch, RAM waitrequest 2 cycles: m0_read addr 0xBFC00000 → s_read=1, s_address=0xBFC00000 for 3 cycles; m0_waitrequest=1,1,0; m0_readdata=RAM word on the third cycle; m1_waitrequest=1 throughout.
- Store then load by m1: write 0xDEADBEEF to 0x00001000 with byteenable 4'b0011, then read the same address → m1 load returns 0x0000BEEF over a zero-initialised word; s_write seen for exactly one completing cycle.
- Simultaneous continuous requests, round-robin: m0 and m1 reading distinct addresses, 0-wait RAM, 6 transfers → order m0,m1,m0,m1,m0,m1; neither waitrequest is low in the same cycle.
- FIXED_PRIORITY=1, both requesting continuously for 4 transfers → all four go to m1; m0 waitrequest stays 1.
- Grant lock: m0 granted with RAM stalling 3 cycles while m1 raises a write in the second cycle → s_address stays m0's, s_write=0 until m0 completes; m1 is served in the next cycle.
- Reset asserted in the stall cycle of an m1 write → same-cycle s_write=0 and both waitrequests=1. After release with both requesting, m0 wins (last=M1).
